// File: rtl/hamming_tx_if.sv
// Handshake and serial-link bundle for hamming_tx.
// inj_pos exists only when HAMM_ERR_INJECT_EN is defined.
interface hamming_tx_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_data;
`ifdef HAMM_ERR_INJECT_EN
  logic [2:0]    inj_pos;
`endif
  logic          tx_bit;
  logic          tx_frame;
  logic          tx_last;
  logic [6:0]    code_out;
  logic [LW-1:0] fifo_level;

`ifdef HAMM_ERR_INJECT_EN
  // Producer / link-observer side.
  modport master (
    output in_valid, in_data, inj_pos,
    input  in_ready, tx_bit, tx_frame, tx_last, code_out, fifo_level
  );
  // Encoder side.
  modport slave (
    input  in_valid, in_data, inj_pos,
    output in_ready, tx_bit, tx_frame, tx_last, code_out, fifo_level
  );
`else
  modport master (
    output in_valid, in_data,
    input  in_ready, tx_bit, tx_frame, tx_last, code_out, fifo_level
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, tx_bit, tx_frame, tx_last, code_out, fifo_level
  );
`endif
endinterface

// File: rtl/hamming_tx.sv
// Hamming(7,4) transmitter: nibble FIFO, encoder and LSB-first serializer with frame markers.
// Optional feature macro: HAMM_ERR_INJECT_EN adds inj_pos to flip one code position at load.
module hamming_tx #(
  parameter int unsigned DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  hamming_tx_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e        state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [6:0]    shift_q, shift_d;
  logic [6:0]    code_q, code_d;
  logic [2:0]    idx_q, idx_d;
  logic          frame_q, frame_d;
  logic          last_q, last_d;

  logic          push, pop, empty, ready;
  logic [6:0]    inj_mask;
  logic [6:0]    next_code;

  // Bit layout matches the receiver's syndrome: position k holds code[k-1].
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Error-injection mask; zero whenever the feature is absent or inj_pos is 0.
  always_comb begin
    inj_mask = '0;
`ifdef HAMM_ERR_INJECT_EN
    if (bus.inj_pos != 3'd0) begin
      inj_mask = 7'b1 << (bus.inj_pos - 3'd1);
    end
`endif
  end

  assign ready     = rst_n && (level_q != LW'(DEPTH));
  assign push      = bus.in_valid && ready;
  assign empty     = (level_q == '0);
  assign next_code = encode(mem_q[rd_ptr_q]) ^ inj_mask;

  // FIFO bookkeeping; a full FIFO refuses pushes even when popping in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Serializer FSM: load on pop, shift out 7 bits, chain directly into the next codeword.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    code_d  = code_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    last_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        shift_d = '0;
        frame_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          code_d  = next_code;
          shift_d = next_code;
          idx_d   = 3'd0;
          frame_d = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (idx_q == 3'd6) begin
          if (!empty) begin
            pop     = 1'b1;
            code_d  = next_code;
            shift_d = next_code;
            idx_d   = 3'd0;
            frame_d = 1'b1;
          end else begin
            shift_d = '0;
            idx_d   = 3'd0;
            frame_d = 1'b0;
            state_d = StIdle;
          end
        end else begin
          idx_d   = idx_q + 3'd1;
          shift_d = shift_q >> 1;
          last_d  = (idx_q == 3'd5);
        end
      end
      default: begin
        state_d = StIdle;
        shift_d = '0;
        frame_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset; aborts any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      shift_q  <= '0;
      code_q   <= '0;
      idx_q    <= '0;
      frame_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      shift_q  <= shift_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      last_q   <= last_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.tx_bit     = shift_q[0];
  assign bus.tx_frame   = frame_q;
  assign bus.tx_last    = last_q;
  assign bus.code_out   = code_q;
  assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_hamming_tx.sv
// Directed, table-driven bench for hamming_tx.
module tb_hamming_tx;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] code;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  vec_t       vecs [16];
  logic [3:0] burst [6];
  int         pushed;
  logic       saw_full;

  always #5 clk = ~clk;

  hamming_tx_if #(.DEPTH(DEPTH)) bus ();

  hamming_tx #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receive-side syndrome: XOR of the 1-based positions of all set bits.
  function automatic logic [2:0] syndrome(input logic [6:0] c);
    logic [2:0] s = 3'd0;
    for (int i = 0; i < 7; i++) if (c[i]) s ^= 3'(i + 1);
    return s;
  endfunction

  function automatic logic [6:0] code_of(input logic [3:0] n);
    return vecs[n].code;
  endfunction

  // Push one nibble into an idle, empty design and check the whole serial frame.
  task automatic send_frame(input vec_t v);
    bus.in_valid = 1'b1;
    bus.in_data  = v.nib;
    tick();
    bus.in_valid = 1'b0;
    check("push_level", 32'(bus.fifo_level), 32'd1);
    tick();
    check("code_out", 32'(bus.code_out), 32'(v.code));
    check("syndrome", 32'(syndrome(bus.code_out)), 32'd0);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      check("frame", 32'(bus.tx_frame), 32'd1);
      check("tx_bit", 32'(bus.tx_bit), 32'(v.code[i]));
      check("tx_last", 32'(bus.tx_last), 32'(i == 6));
    end
    tick();
    check("frame_end", 32'(bus.tx_frame), 32'd0);
    check("level_end", 32'(bus.fifo_level), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{4'h0, 7'h00}; vecs[1]  = '{4'h1, 7'h07};
    vecs[2]  = '{4'h2, 7'h19}; vecs[3]  = '{4'h3, 7'h1E};
    vecs[4]  = '{4'h4, 7'h2A}; vecs[5]  = '{4'h5, 7'h2D};
    vecs[6]  = '{4'h6, 7'h33}; vecs[7]  = '{4'h7, 7'h34};
    vecs[8]  = '{4'h8, 7'h4B}; vecs[9]  = '{4'h9, 7'h4C};
    vecs[10] = '{4'hA, 7'h52}; vecs[11] = '{4'hB, 7'h55};
    vecs[12] = '{4'hC, 7'h61}; vecs[13] = '{4'hD, 7'h66};
    vecs[14] = '{4'hE, 7'h78}; vecs[15] = '{4'hF, 7'h7F};
    burst[0] = 4'h3; burst[1] = 4'h5; burst[2] = 4'h9;
    burst[3] = 4'hA; burst[4] = 4'hC; burst[5] = 4'h6;

    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
`ifdef HAMM_ERR_INJECT_EN
    bus.inj_pos  = 3'd0;
`endif

    // Reset held 3 cycles with in_valid high.
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_ready", 32'(bus.in_ready), 32'd0);
      check("rst_bit", 32'(bus.tx_bit), 32'd0);
      check("rst_frame", 32'(bus.tx_frame), 32'd0);
      check("rst_last", 32'(bus.tx_last), 32'd0);
      check("rst_code", 32'(bus.code_out), 32'd0);
      check("rst_level", 32'(bus.fifo_level), 32'd0);
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    tick();
    check("ready_after_rst", 32'(bus.in_ready), 32'd1);
    check("level_after_rst", 32'(bus.fifo_level), 32'd0);
    check("idle_after_rst", 32'(bus.tx_frame), 32'd0);

    // Encode sweep over every nibble (includes 4'hB -> 7'h55).
    for (int v = 0; v < 16; v++) send_frame(vecs[v]);

    // Burst of DEPTH+2 nibbles with in_valid held high.
    pushed   = 0;
    saw_full = 1'b0;
    fork
      begin : driver
        for (int c = 0; c < 100 && pushed < 6; c++) begin
          logic rdy;
          bus.in_valid = 1'b1;
          bus.in_data  = burst[pushed];
          rdy = bus.in_ready;
          check("ready_vs_level", 32'(rdy), 32'(bus.fifo_level != LW'(DEPTH)));
          if (!rdy) saw_full = 1'b1;
          tick();
          if (rdy) pushed++;
        end
        bus.in_valid = 1'b0;
      end
      begin : monitor
        int w;
        for (w = 0; w < 20 && !bus.tx_frame; w++) tick();
        check("burst_start", 32'(bus.tx_frame), 32'd1);
        for (int f = 0; f < 6; f++) begin
          for (int i = 0; i < 7; i++) begin
            logic [6:0] exp_code;
            exp_code = code_of(burst[f]);
            check("burst_frame", 32'(bus.tx_frame), 32'd1);
            check("burst_bit", 32'(bus.tx_bit), 32'(exp_code[i]));
            check("burst_last", 32'(bus.tx_last), 32'(i == 6));
            if (i == 0) check("burst_code", 32'(bus.code_out), 32'(exp_code));
            tick();
          end
        end
        check("burst_end", 32'(bus.tx_frame), 32'd0);
      end
    join
    check("burst_pushed", 32'(pushed), 32'd6);
    check("burst_full_seen", 32'(saw_full), 32'd1);
    check("burst_level", 32'(bus.fifo_level), 32'd0);

    // Reset at bit 3 of a frame with two nibbles queued.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h8;
    tick();
    bus.in_data  = 4'h2;
    tick();
    bus.in_data  = 4'h3;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("mid_frame", 32'(bus.tx_frame), 32'd1);
    check("mid_bit3", 32'(bus.tx_bit), 32'(1'b1));
    check("mid_level", 32'(bus.fifo_level), 32'd2);
    rst_n = 1'b0;
    tick();
    check("abort_frame", 32'(bus.tx_frame), 32'd0);
    check("abort_level", 32'(bus.fifo_level), 32'd0);
    check("abort_code", 32'(bus.code_out), 32'd0);
    check("abort_bit", 32'(bus.tx_bit), 32'd0);
    rst_n = 1'b1;
    begin
      int frames = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (bus.tx_frame) frames++;
      end
      check("no_frames_after_abort", 32'(frames), 32'd0);
    end

`ifdef HAMM_ERR_INJECT_EN
    // Single-bit injection at position 3 must still decode to the original nibble.
    begin
      logic [6:0] c;
      logic [2:0] s;
      bus.inj_pos  = 3'd3;
      bus.in_valid = 1'b1;
      bus.in_data  = 4'hB;
      tick();
      bus.in_valid = 1'b0;
      tick();
      bus.inj_pos  = 3'd0;
      check("inj_code", 32'(bus.code_out), 32'h51);
      c = bus.code_out;
      s = syndrome(c);
      check("inj_syndrome", 32'(s), 32'd3);
      if (s != 3'd0) c[s - 3'd1] = ~c[s - 3'd1];
      check("inj_recovered", 32'({c[6], c[5], c[4], c[2]}), 32'hB);
      for (int i = 0; i < 8; i++) tick();
      check("inj_idle", 32'(bus.tx_frame), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hamming_tx.md
# hamming_tx

Transmit-side companion to the Hamming(7,4) receive corrector in the secure-routing path. Accepts 4-bit data nibbles over a valid/ready handshake and buffers them in a small FIFO. Encodes each nibble into a 7-bit Hamming codeword and serializes it LSB-first onto a 1-bit link with frame markers. The bit layout matches the receive-side syndrome decode exactly, so any single-bit link error is correctable downstream.

## Interface
- DEPTH, 4, input FIFO depth in nibbles; must be a power of 2 and at least 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  producer has a nibble on in_data.
- in_ready  out  1  FIFO can accept a nibble.
- in_data  in  4  data nibble d[3:0].
- inj_pos  in  3  error-injection position; present only with HAMM_ERR_INJECT_EN.
- tx_bit  out  1  serial codeword bit, LSB (code position 1) first.
- tx_frame  out  1  high for each of the 7 bit cycles of a codeword.
- tx_last  out  1  high on the 7th bit (code[6]) only.
- code_out  out  7  full codeword being shifted; held stable for the whole frame.
- fifo_level  out  $clog2(DEPTH)+1  number of nibbles currently buffered.

## Operation
- Push: a nibble is written when in_valid && in_ready is true at a rising edge.
- in_ready is 0 while rst_n=0; otherwise in_ready = (fifo_level != DEPTH).
- When the FIFO is full, no push is accepted, even if a pop occurs in the same cycle.
- A simultaneous push and pop on a non-full FIFO leaves fifo_level unchanged.
- Pointers wrap modulo DEPTH.
- Encode rule:
  - p1 = d0^d1^d3
  - p2 = d0^d2^d3
  - p4 = d1^d2^d3
- Codeword bit order: code[0]=p1, code[1]=p2, code[2]=d0, code[3]=p4, code[4]=d1, code[5]=d2, code[6]=d3.
- FSM has two states, IDLE and SHIFT.
  - IDLE: if the FIFO is non-empty, pop, encode, and load code_out and the shift register; set bit index 0; go to SHIFT. Otherwise stay in IDLE with tx_bit=0, tx_frame=0.
  - SHIFT: tx_bit = code[idx] and tx_frame = 1. tx_last = 1 when idx = 6.
  - At idx = 6: if the FIFO is non-empty, pop and load the next codeword with idx = 0, staying in SHIFT with no gap cycle. Otherwise go to IDLE.
- Reset (rst_n=0 sampled at an edge), including mid-frame:
  - FIFO emptied, fifo_level = 0, state = IDLE.
  - tx_bit = 0, tx_frame = 0, tx_last = 0, code_out = 0.
  - Any partial frame is aborted and its nibble is discarded.

## Timing
- A nibble pushed at edge N into an empty FIFO while in IDLE is popped at edge N+1. Its first bit (code[0]) is on tx_bit from edge N+1, and its last bit from edge N+7.
- All serial outputs are registered.
- Sustained throughput is 1 nibble per 7 cycles. Back-to-back frames keep tx_frame continuously high.
- fifo_level updates on the edge of the push or pop.

## Configuration
- HAMM_ERR_INJECT_EN defined:
  - The inj_pos port exists and is sampled on the load edge.
  - inj_pos = 0 leaves the codeword unmodified.
  - inj_pos = k (1..7) inverts code[k-1] before it is stored in code_out and the shift register. This uses the same 1-based position convention as the receive corrector's syndrome.
- HAMM_ERR_INJECT_EN undefined: no inj_pos port, and codewords are always clean.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, all outputs 0, fifo_level=0. Release -> in_ready=1 on the next cycle.
- Single nibble 4'hB -> code_out=7'h55; tx_bit sequence 1,0,1,0,1,0,1; tx_frame high 7 cycles; tx_last on the 7th only; then IDLE.
- Encode sweep 0..F -> each codeword has a zero receive-side syndrome. Spot checks: 0 -> 7'h00, 1 -> 7'h07, F -> 7'h7F.
- Burst of DEPTH+2 pushes with in_valid held high -> in_ready drops when fifo_level=DEPTH. Frames are back-to-back with no tx_frame gap, the data order is preserved, and no nibble is lost or duplicated.
- Reset asserted at bit 3 of a frame with 2 nibbles queued -> next edge: tx_frame=0, fifo_level=0; no further frames are sent.
- With HAMM_ERR_INJECT_EN: nibble 4'hB with inj_pos=3 -> code_out=7'h51. The receive corrector recovers 4'hB.
